button_event: RTL and testbench



---
 rtl/button_event_pkg.sv | 14 +
 rtl/btn_edge_det.sv | 30 +++
 rtl/button_event.sv | 144 ++++++++++++++
 tb/tb_button_event.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared types and widths for the button event classifier
package button_event_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG,
        WAIT2,
        HOLD2
    } btn_state_e;

endpackage

// File: rtl/btn_edge_det.sv
// rtl/btn_edge_det.sv - registers a synchronous level and flags its rising/falling edges
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_q,
    output logic rise,
    output logic fall
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = btn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign btn_q = level_q;
    assign rise  = btn & ~level_q;
    assign fall  = ~btn & level_q;

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - classifies a debounced button into press/release/click/double/long/repeat pulses
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 100000000,
    parameter int DCLICK_CYCLES = 30000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_p,
    output logic release_p,
    output logic click_p,
    output logic dclick_p,
    output logic long_p,
    output logic repeat_p,
    output logic held
);

    generate
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("LONG_CYCLES must be at least 2");
        end
        if (DCLICK_CYCLES < 2) begin : g_bad_dclick
            $error("DCLICK_CYCLES must be at least 2");
        end
        if (REPEAT_CYCLES < 2) begin : g_bad_repeat
            $error("REPEAT_CYCLES must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic btn_q;
    logic rise;
    logic fall;

    btn_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .btn_q (btn_q),
        .rise  (rise),
        .fall  (fall)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             dclick_q, dclick_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             restart;

    // Release and second-press edges are tested before the timeouts so they win ties.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        press_d   = rise;
        release_d = fall;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    restart  = 1'b1;
                end
            end
            WAIT2: begin
                if (rise) begin
                    dclick_d = 1'b1;
                    state_d  = HOLD2;
                end else if (cnt_q == DCLICK_LAST) begin
                    click_d = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD2: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || restart) begin
            cnt_d = '0;
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign press_p   = press_q;
    assign release_p = release_q;
    assign click_p   = click_q;
    assign dclick_p  = dclick_q;
    assign long_p    = long_q;
    assign repeat_p  = repeat_q;
    assign held      = btn_q;

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - randomized and directed check of button_event against a timestamp model
module tb_button_event;

    localparam int LONG_C   = 20;
    localparam int DCLICK_C = 10;
    localparam int REPEAT_C = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_FIRST = 1;
    localparam int PH_LONG  = 2;
    localparam int PH_GAP   = 3;
    localparam int PH_SECND = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic press_p, release_p, click_p, dclick_p, long_p, repeat_p, held;

    button_event #(
        .LONG_CYCLES   (LONG_C),
        .DCLICK_CYCLES (DCLICK_C),
        .REPEAT_CYCLES (REPEAT_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .press_p   (press_p),
        .release_p (release_p),
        .click_p   (click_p),
        .dclick_p  (dclick_p),
        .long_p    (long_p),
        .repeat_p  (repeat_p),
        .held      (held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase plus the edge index at which that phase (or repeat period) began.
    int   now = 0;
    int   ph  = PH_IDLE;
    int   t0  = 0;
    logic m_prev = 1'b0;
    logic e_press, e_release, e_click, e_dclick, e_long, e_repeat, e_held;
    int   n_click = 0, n_dclick = 0, n_long = 0, n_repeat = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, want %0d", tag, now, obs, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic rs, fl;
        now++;
        e_press = 0; e_release = 0; e_click = 0; e_dclick = 0;
        e_long = 0; e_repeat = 0; e_held = 0;
        if (!r) begin
            m_prev = 1'b0;
            ph     = PH_IDLE;
            return;
        end
        rs = b & ~m_prev;
        fl = ~b & m_prev;
        e_press   = rs;
        e_release = fl;
        e_held    = b;
        m_prev    = b;
        case (ph)
            PH_IDLE:  if (rs) begin ph = PH_FIRST; t0 = now; end
            PH_FIRST: begin
                if (fl) begin ph = PH_GAP; t0 = now; end
                else if (now - t0 == LONG_C) begin e_long = 1; ph = PH_LONG; t0 = now; end
            end
            PH_LONG: begin
                if (fl) ph = PH_IDLE;
                else if (now - t0 == REPEAT_C) begin e_repeat = 1; t0 = now; end
            end
            PH_GAP: begin
                if (rs) begin e_dclick = 1; ph = PH_SECND; end
                else if (now - t0 == DCLICK_C) begin e_click = 1; ph = PH_IDLE; end
            end
            default:  if (fl) ph = PH_IDLE;
        endcase
        n_click  += int'(e_click);
        n_dclick += int'(e_dclick);
        n_long   += int'(e_long);
        n_repeat += int'(e_repeat);
    endtask

    task automatic step(input logic b, input logic r);
        btn   = b;
        rst_n = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
        check("press_p",   press_p,   e_press);
        check("release_p", release_p, e_release);
        check("click_p",   click_p,   e_click);
        check("dclick_p",  dclick_p,  e_dclick);
        check("long_p",    long_p,    e_long);
        check("repeat_p",  repeat_p,  e_repeat);
        check("held",      held,      e_held);
        check("class_onehot", ($countones({click_p, dclick_p, long_p, repeat_p}) <= 1), 1);
        check("press_rel_excl", (press_p & release_p), 0);
    endtask

    task automatic run(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    initial begin
        btn   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // single click
        run(1, 5);  run(0, 16);
        check("t1_click_seen", n_click, 1);
        // double click
        run(1, 4);  run(0, 3);  run(1, 4);  run(0, 12);
        check("t2_dclick_seen", n_dclick, 1);
        // long press with repeats
        run(1, 32); run(0, 10);
        check("t3_long_seen", n_long, 1);
        check("t3_repeat_seen", n_repeat, 2);
        // release on long-declare edge, then click
        run(1, LONG_C); run(0, 15);
        check("t4a_no_long", n_long, 1);
        check("t4a_click", n_click, 2);
        // release on long-declare edge, second press on gap-expiry edge
        run(1, LONG_C); run(0, DCLICK_C); run(1, 3); run(0, 12);
        check("t4b_dclick", n_dclick, 2);
        check("t4b_no_click", n_click, 2);
        // reset mid-long with button held
        run(1, 25);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run(1, 24); run(0, 12);
        check("t5_long_after_reset", n_long, 3);

        // randomized level segments with occasional reset
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    step(1'($urandom_range(0, 1)), 1'b0);
            end
            run(1'(seg % 2 == 0), int'($urandom_range(1, 35)));
        end
        run(0, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
